// File: rtl/tx_uart_pkg.sv
// Shared UART constants: transmitter FSM encoding, frame geometry, FIFO depth.
package tx_uart_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  localparam int DATA_BITS     = 8;
  localparam int FRAME_BITS    = 10;
  localparam int TX_FIFO_DEPTH = 16;
  localparam int CNT_W         = 17;

  // div=0 is treated as one clock per bit
  function automatic logic [CNT_W-1:0] bit_time(input logic [15:0] d);
    return (d == 16'd0) ? CNT_W'(1) : CNT_W'(d);
  endfunction
endpackage

// File: rtl/tx_uart_fifo.sv
// Show-ahead synchronous FIFO; push ignored when full, pop ignored when empty.
module tx_uart_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_din,
  input  logic                  i_pop,
  output logic [DATA_WIDTH-1:0] o_dout,
  output logic                  o_empty,
  output logic                  o_full
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wp, r_rp;
  logic [AW:0]           r_cnt;
  logic                  w_push, w_pop;

  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_empty = (r_cnt == '0);
  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  assign o_dout  = r_mem[r_rp];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= i_din;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end
endmodule

// File: rtl/tx_uart.sv
// 8N1 UART transmitter. TX_UART_FIFO_EN selects a 16-entry write FIFO,
// otherwise a single holding register buffers the next byte.
module tx_uart
  import tx_uart_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic [7:0]  tx_data,
  input  logic        data_we,
  input  logic [15:0] div,
  output logic        tx_out,
  output logic        ready,
  output logic        busy
);
  tx_state_e        r_state;
  logic [7:0]       r_shift;
  logic [2:0]       r_bitn;
  logic [CNT_W-1:0] r_cnt, r_bt;
  logic             r_line, r_tx;

  logic             w_accept, w_empty, w_full, w_push, w_pop, w_load, w_bit_end;
  logic [7:0]       w_qdata, w_src;

  assign w_accept  = data_we && !w_full;
  assign w_bit_end = ((r_cnt + 1'b1) == r_bt);
  // a frame starts from IDLE on any byte, or straight out of a finishing stop bit
  assign w_load    = ((r_state == ST_IDLE) && (!w_empty || w_accept)) ||
                     ((r_state == ST_STOP) && w_bit_end && !w_empty);
  assign w_pop     = w_load && !w_empty;
  assign w_src     = w_empty ? tx_data : w_qdata;
  assign w_push    = w_accept && !(w_load && w_empty);

`ifdef TX_UART_FIFO_EN
  tx_uart_fifo #(.DATA_WIDTH(DATA_BITS), .DEPTH(TX_FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .i_push (w_push),
    .i_din  (tx_data),
    .i_pop  (w_pop),
    .o_dout (w_qdata),
    .o_empty(w_empty),
    .o_full (w_full)
  );
`else
  logic       r_hold_vld;
  logic [7:0] r_hold;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_hold_vld <= 1'b0;
      r_hold     <= '0;
    end else if (w_push) begin
      r_hold_vld <= 1'b1;
      r_hold     <= tx_data;
    end else if (w_pop) begin
      r_hold_vld <= 1'b0;
    end
  end

  assign w_empty = !r_hold_vld;
  assign w_full  = r_hold_vld;
  assign w_qdata = r_hold;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_shift <= '0;
      r_bitn  <= '0;
      r_cnt   <= '0;
      r_bt    <= CNT_W'(1);
    end else if (w_load) begin
      r_state <= ST_START;
      r_shift <= w_src;
      r_bitn  <= '0;
      r_cnt   <= '0;
      r_bt    <= bit_time(div);
    end else begin
      case (r_state)
        ST_START: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_state <= ST_DATA;
          end else r_cnt <= r_cnt + 1'b1;
        end
        ST_DATA: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_shift <= r_shift >> 1;
            if (r_bitn == 3'(DATA_BITS-1)) r_state <= ST_STOP;
            else r_bitn <= r_bitn + 1'b1;
          end else r_cnt <= r_cnt + 1'b1;
        end
        ST_STOP: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_state <= ST_IDLE;
          end else r_cnt <= r_cnt + 1'b1;
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  // two output stages put the start bit on the wire 2 edges after acceptance
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_line <= 1'b1;
      r_tx   <= 1'b1;
    end else begin
      case (r_state)
        ST_START: r_line <= 1'b0;
        ST_DATA:  r_line <= r_shift[0];
        default:  r_line <= 1'b1;
      endcase
      r_tx <= r_line;
    end
  end

  assign tx_out = r_tx;
  assign ready  = !w_full;
  assign busy   = (r_state != ST_IDLE) || !w_empty;
endmodule

// File: tb/tb_tx_uart.sv
// Directed bench for tx_uart: waveform, back-to-back, buffering, loopback, div=0, reset abort.
module tb_tx_uart;
  logic        clk = 1'b0;
  logic        resetn;
  logic [7:0]  tx_data;
  logic        data_we;
  logic [15:0] div;
  logic        tx_out, ready, busy;

  int n_pass = 0;
  int n_total = 0;
  logic exp_q[$];

  tx_uart dut (
    .clk(clk), .resetn(resetn), .tx_data(tx_data), .data_we(data_we),
    .div(div), .tx_out(tx_out), .ready(ready), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // expected per-clock line level of one 8N1 frame
  task automatic push_frame(input logic [7:0] b, input int d);
    int de;
    de = (d == 0) ? 1 : d;
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < de; c++)
        exp_q.push_back((i == 0) ? 1'b0 : (i == 9) ? 1'b1 : b[i-1]);
    end
  endtask

  // returns right after the accepting edge
  task automatic write_byte(input logic [7:0] b);
    @(negedge clk);
    tx_data = b;
    data_we = 1'b1;
    @(posedge clk);
    #1 data_we = 1'b0;
  endtask

  task automatic rx_frame(input int d, input int tmo, output logic [7:0] b,
                          output logic err, output logic to);
    int de;
    de = (d == 0) ? 1 : d;
    to = 1'b1; err = 1'b0; b = '0;
    for (int n = 0; n < tmo; n++) begin
      @(negedge clk);
      if (tx_out === 1'b0) begin
        to = 1'b0;
        break;
      end
    end
    if (!to) begin
      repeat (de/2) @(negedge clk);
      if (tx_out !== 1'b0) err = 1'b1;
      for (int i = 0; i < 8; i++) begin
        repeat (de) @(negedge clk);
        b[i] = tx_out;
      end
      repeat (de) @(negedge clk);
      if (tx_out !== 1'b1) err = 1'b1;
    end
  endtask

  task automatic settle();
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    resetn = 1'b0; data_we = 1'b0; tx_data = '0; div = 16'd4;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_total++; if (tx_out !== 1'b1) $display("FAIL reset_tx got %b exp 1", tx_out); else n_pass++;
    n_total++; if (ready !== 1'b1) $display("FAIL reset_ready got %b exp 1", ready); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else n_pass++;
    resetn = 1'b1;
    settle();
  endtask

  task automatic test_frame55();
    logic e;
    div = 16'd4;
    exp_q.delete();
    push_frame(8'h55, 4);
    write_byte(8'h55);
    for (int j = 0; j < 50; j++) begin
      @(negedge clk);
      e = (j >= 2 && j - 2 < exp_q.size()) ? exp_q[j-2] : 1'b1;
      n_total++; if (tx_out !== e) $display("FAIL f55_tx j=%0d got %b exp %b", j, tx_out, e); else n_pass++;
      n_total++; if (busy !== (j < 40)) $display("FAIL f55_busy j=%0d got %b exp %b", j, busy, j < 40); else n_pass++;
      if (j == 0) begin
        n_total++; if (ready !== 1'b1) $display("FAIL f55_ready got %b exp 1", ready); else n_pass++;
      end
    end
    settle();
  endtask

  task automatic test_back_to_back();
    logic e;
    div = 16'd8;
    exp_q.delete();
    push_frame(8'hA5, 8);
    push_frame(8'h3C, 8);
    @(negedge clk);
    tx_data = 8'hA5; data_we = 1'b1;
    @(posedge clk);
    #1 tx_data = 8'h3C;
    @(posedge clk);
    #1 data_we = 1'b0;
    for (int j = 1; j < 170; j++) begin
      @(negedge clk);
      e = (j >= 2 && j - 2 < exp_q.size()) ? exp_q[j-2] : 1'b1;
      n_total++; if (tx_out !== e) $display("FAIL b2b_tx j=%0d got %b exp %b", j, tx_out, e); else n_pass++;
      n_total++; if (busy !== (j < 160)) $display("FAIL b2b_busy j=%0d got %b exp %b", j, busy, j < 160); else n_pass++;
    end
    settle();
  endtask

  task automatic test_div0();
    logic e;
    div = 16'd0;
    exp_q.delete();
    push_frame(8'h81, 0);
    write_byte(8'h81);
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      e = (j >= 2 && j - 2 < exp_q.size()) ? exp_q[j-2] : 1'b1;
      n_total++; if (tx_out !== e) $display("FAIL div0_tx j=%0d got %b exp %b", j, tx_out, e); else n_pass++;
      if (j == 3) div = 16'd20;
    end
    settle();
    exp_q.delete();
    push_frame(8'h01, 20);
    write_byte(8'h01);
    for (int j = 0; j < 210; j++) begin
      @(negedge clk);
      e = (j >= 2 && j - 2 < exp_q.size()) ? exp_q[j-2] : 1'b1;
      n_total++; if (tx_out !== e) $display("FAIL div20_tx j=%0d got %b exp %b", j, tx_out, e); else n_pass++;
    end
    settle();
  endtask

  task automatic test_loopback();
    logic [7:0] vec [3];
    logic [7:0] b;
    logic err, to;
    bit got_rdy;
    vec[0] = 8'h00; vec[1] = 8'hFF; vec[2] = 8'h5A;
    div = 16'd16;
    fork
      begin
        write_byte(vec[0]);
        write_byte(vec[1]);
        got_rdy = 1'b0;
        for (int n = 0; n < 1000 && !got_rdy; n++) begin
          @(negedge clk);
          if (ready === 1'b1) got_rdy = 1'b1;
        end
        n_total++; if (!got_rdy) $display("FAIL loop_ready_wait got timeout exp ready"); else n_pass++;
        if (got_rdy) begin
          tx_data = vec[2]; data_we = 1'b1;
          @(posedge clk);
          #1 data_we = 1'b0;
        end
      end
      begin
        for (int i = 0; i < 3; i++) begin
          rx_frame(16, 1000, b, err, to);
          n_total++; if (to || b !== vec[i]) $display("FAIL loop_byte%0d got %h (to=%b) exp %h", i, b, to, vec[i]); else n_pass++;
          n_total++; if (err !== 1'b0) $display("FAIL loop_err%0d got %b exp 0", i, err); else n_pass++;
        end
      end
    join
    settle();
  endtask

`ifdef TX_UART_FIFO_EN
  task automatic test_fifo();
    logic [7:0] b;
    logic err, to;
    div = 16'd100;
    fork
      begin
        for (int i = 1; i <= 18; i++) begin
          @(negedge clk);
          if (i == 17) begin
            n_total++; if (ready !== 1'b1) $display("FAIL fifo_ready16 got %b exp 1", ready); else n_pass++;
          end
          if (i == 18) begin
            n_total++; if (ready !== 1'b0) $display("FAIL fifo_ready17 got %b exp 0", ready); else n_pass++;
          end
          tx_data = 8'(i); data_we = 1'b1;
          @(posedge clk);
        end
        #1 data_we = 1'b0;
      end
      begin
        for (int i = 1; i <= 17; i++) begin
          rx_frame(100, 1500, b, err, to);
          n_total++; if (to || err || b !== 8'(i)) $display("FAIL fifo_frame%0d got %h (to=%b err=%b) exp %h", i, b, to, err, 8'(i)); else n_pass++;
        end
        rx_frame(100, 1500, b, err, to);
        n_total++; if (to !== 1'b1) $display("FAIL fifo_extra got frame %h exp none", b); else n_pass++;
      end
    join
    settle();
  endtask
`else
  task automatic test_hold();
    logic [7:0] b;
    logic err, to;
    div = 16'd10;
    fork
      begin
        for (int i = 1; i <= 3; i++) begin
          @(negedge clk);
          if (i == 2) begin
            n_total++; if (ready !== 1'b1) $display("FAIL hold_ready1 got %b exp 1", ready); else n_pass++;
          end
          if (i == 3) begin
            n_total++; if (ready !== 1'b0) $display("FAIL hold_ready2 got %b exp 0", ready); else n_pass++;
          end
          tx_data = 8'(i * 17); data_we = 1'b1;
          @(posedge clk);
        end
        #1 data_we = 1'b0;
      end
      begin
        for (int i = 1; i <= 2; i++) begin
          rx_frame(10, 200, b, err, to);
          n_total++; if (to || err || b !== 8'(i * 17)) $display("FAIL hold_frame%0d got %h (to=%b err=%b) exp %h", i, b, to, err, 8'(i * 17)); else n_pass++;
        end
        rx_frame(10, 200, b, err, to);
        n_total++; if (to !== 1'b1) $display("FAIL hold_extra got frame %h exp none", b); else n_pass++;
      end
    join
    settle();
  endtask
`endif

  task automatic test_reset_mid();
    int bad;
    div = 16'd4;
    @(negedge clk);
    tx_data = 8'hF0; data_we = 1'b1;
    @(posedge clk);
    for (int i = 1; i <= 3; i++) begin
      #1 tx_data = 8'(i);
      @(posedge clk);
    end
    #1 data_we = 1'b0;
    repeat (14) @(posedge clk);
    #1 resetn = 1'b0;
    n_total++; if (busy !== 1'b1) $display("FAIL rmid_busy_before got %b exp 1", busy); else n_pass++;
    @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    n_total++; if (tx_out !== 1'b1) $display("FAIL rmid_tx got %b exp 1", tx_out); else n_pass++;
    n_total++; if (ready !== 1'b1) $display("FAIL rmid_ready got %b exp 1", ready); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL rmid_busy got %b exp 0", busy); else n_pass++;
    bad = 0;
    for (int j = 0; j < 300; j++) begin
      @(negedge clk);
      if (tx_out !== 1'b1 || busy !== 1'b0) bad++;
    end
    n_total++; if (bad != 0) $display("FAIL rmid_no_resume got %0d active clks exp 0", bad); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_frame55();
    test_back_to_back();
    test_div0();
    test_loopback();
`ifdef TX_UART_FIFO_EN
    test_fifo();
`else
    test_hold();
`endif
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/tx_uart.md
TX_UART -- requirements
Module: tx_uart

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all logic on rising edge.
REQ-002 SHALL have port resetn, input, 1 bit: synchronous, active-low reset.
REQ-003 SHALL have port tx_data, input, 8 bits: byte to transmit.
REQ-004 SHALL have port data_we, input, 1 bit: write strobe; tx_data accepted on the edge where data_we=1 and ready=1.
REQ-005 SHALL have port div, input, 16 bits: clocks per bit; same encoding as the receiver's div.
REQ-006 SHALL have port tx_out, output, 1 bit: serial line, registered; drives the receiver's rx_in.
REQ-007 SHALL have port ready, output, 1 bit: space available for one more byte.
REQ-008 SHALL have port busy, output, 1 bit: frame in progress or byte pending.

Function
REQ-009 SHALL transmit 8N1 frames: start bit 0, data bits LSB first, one stop bit 1.
REQ-010 SHALL hold each bit for max(div,1) clocks; div=0 SHALL behave as div=1.
REQ-011 SHALL latch div at frame start; div changes mid-frame SHALL take effect from the next frame.
REQ-012 SHALL use states IDLE, START, DATA, STOP; IDLE->START on pending byte, START->DATA after one bit time, DATA->STOP after bit 7, STOP->START if a byte is pending else IDLE.
REQ-013 SHALL drive tx_out low exactly 2 clock edges after the accepting edge when IDLE (write edge k, tx_out=0 after edge k+2).
REQ-014 SHALL send back-to-back frames with no idle gap: next start bit begins on the edge the stop bit ends.
REQ-015 SHALL ignore writes while ready=0; no state change, byte dropped.
REQ-016 SHALL keep tx_out=1 whenever IDLE.
REQ-017 SHALL assert busy when not IDLE or a byte is pending; deassert the edge STOP->IDLE.
REQ-018 SHALL keep the bit-time counter at least 17 bits wide; no wrap at div=16'hFFFF.

Reset
REQ-019 SHALL on resetn=0 set tx_out=1, ready=1, busy=0, state IDLE, flush all pending bytes.
REQ-020 SHALL abort any frame on reset mid-operation; tx_out=1 after the reset edge; truncated frame not resumed.

Configuration
REQ-021 SHALL with TX_UART_FIFO_EN defined buffer writes in a 16-entry FIFO; ready = FIFO not full.
REQ-022 SHALL without TX_UART_FIFO_EN use one holding register; ready=0 while it is occupied; REQ-013 latency unchanged.

Structure
REQ-023 SHALL take state encodings, TX_FIFO_DEPTH=16, and frame length constants from the shared UART package.
REQ-024 SHALL instantiate the existing fifo sub-module (DATA_WIDTH=8, DEPTH=16) only under TX_UART_FIFO_EN.

Verification
REQ-025 SHALL cover: div=4, write 0x55 -> tx_out 0 for 4 clks, then 1,0,1,0,1,0,1,0 at 4 clks each, then 1 for 4; busy high 40 clks.
REQ-026 SHALL cover: div=8, writes 0xA5 then 0x3C on consecutive edges -> 160 contiguous clks of framing, no gap, busy drops afterwards.
REQ-027 SHALL cover: FIFO_EN, div=100, 18 writes on consecutive edges -> ready low after 17th, 18th dropped, exactly 17 frames sent.
REQ-028 SHALL cover: loopback tx_out->receiver rx_in, div=16, bytes 0x00,0xFF,0x5A -> receiver returns the same bytes, error never set.
REQ-029 SHALL cover: div=0 write 0x81 -> 10 bits of 1 clk each; div changed to 20 mid-frame -> current frame stays at 1 clk/bit.
REQ-030 SHALL cover: resetn low at bit 3 of 0xF0 with 3 bytes queued -> tx_out=1, ready=1, busy=0 next edge, no further frames.
